// File: rtl/i2s_sample_rx.sv
// I2S capture receiver: synchronised BCLK/LRCK/DAT into MSB-aligned stereo pairs.
// Define I2S_RX_TIMEOUT_EN to build in the BCLK-loss watchdog.
module i2s_sample_rx #(
    parameter int DATA_BITS      = 24,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               AUD_BCLK,
    input  logic               AUD_ADCLRCK,
    input  logic               AUD_ADCDAT,
    output logic signed [31:0] out_L,
    output logic signed [31:0] out_R,
    output logic               tick,
    output logic               locked,
    output logic               frame_err,
    input  logic               clr_err
);
    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    localparam logic [5:0] NBITS = 6'(DATA_BITS);

    // bit 2 = BCLK, bit 1 = LRCK, bit 0 = DAT
    logic [2:0]  sync1;
    logic [2:0]  sync2;
    logic        bclk_prev;
    logic        lr_prev;
    state_t      state;
    state_t      state_nxt;
    logic [5:0]  cnt;
    logic [31:0] sh;
    logic [31:0] left_word;
    logic [31:0] word;
    logic        lr;
    logic        dat;
    logic        rise;
    logic        boundary;
    logic        lost;
    logic        shift_en;
    logic        restart;
    logic        commit_left;
    logic        commit_pair;
    logic        short_word;

    assign lr       = sync2[1];
    assign dat      = sync2[0];
    assign rise     = sync2[2] & ~bclk_prev;
    assign boundary = rise & (lr != lr_prev);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= '0;
            sync2     <= '0;
            bclk_prev <= 1'b0;
            lr_prev   <= 1'b0;
        end else begin
            sync1     <= {AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT};
            sync2     <= sync1;
            bclk_prev <= sync2[2];
            if (rise)
                lr_prev <= lr;
        end
    end

`ifdef I2S_RX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wd;

    assign lost = !rise && (wd == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            wd <= '0;
        else if (rise || lost)
            wd <= '0;
        else
            wd <= wd + 1'b1;
    end
`else
    // No watchdog: a stalled BCLK never drops the link.
    assign lost = (TIMEOUT_CYCLES < 1);
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            state <= SYNC;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        shift_en    = 1'b0;
        restart     = 1'b0;
        commit_left = 1'b0;
        commit_pair = 1'b0;
        short_word  = 1'b0;
        if (lost) begin
            state_nxt = SYNC;
            restart   = 1'b1;
        end else if (boundary) begin
            unique case (state)
                SYNC: begin
                    if (!lr) begin
                        state_nxt = LEFT;
                        restart   = 1'b1;
                    end
                end
                LEFT: begin
                    state_nxt = RIGHT;
                    restart   = 1'b1;
                    if (cnt < NBITS) begin
                        commit_left = 1'b1;
                        short_word  = 1'b1;
                    end
                end
                RIGHT: begin
                    state_nxt = LEFT;
                    restart   = 1'b1;
                    if (cnt < NBITS) begin
                        commit_pair = 1'b1;
                        short_word  = 1'b1;
                    end
                end
                default: state_nxt = SYNC;
            endcase
        end else if (rise && state != SYNC && cnt < NBITS) begin
            shift_en = 1'b1;
            if (cnt == NBITS - 6'd1) begin
                commit_left = (state == LEFT);
                commit_pair = (state == RIGHT);
            end
        end
    end

    // Bits land MSB-first from bit 31 down, so partial words are LSB zero-padded.
    always_comb begin
        word = sh;
        if (shift_en)
            word[5'(6'd31 - cnt)] = dat;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            sh        <= '0;
            left_word <= '0;
            out_L     <= '0;
            out_R     <= '0;
            tick      <= 1'b0;
            locked    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            tick <= commit_pair;
            if (restart) begin
                cnt <= '0;
                sh  <= '0;
            end else if (shift_en) begin
                cnt <= cnt + 6'd1;
                sh  <= word;
            end
            if (commit_left)
                left_word <= word;
            if (commit_pair) begin
                out_L  <= left_word;
                out_R  <= word;
                locked <= 1'b1;
            end
            if (lost) begin
                out_L  <= '0;
                out_R  <= '0;
                locked <= 1'b0;
            end
            if (short_word)
                frame_err <= 1'b1;
            else if (clr_err)
                frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Directed + randomized bench for i2s_sample_rx against a slot-level reference model.
// Watchdog expectations follow I2S_RX_TIMEOUT_EN.
module tb_i2s_sample_rx;
    localparam int DB   = 24;
    localparam int FULL = 33;

    logic               CLOCK_50 = 1'b0;
    logic               reset_n;
    logic               AUD_BCLK;
    logic               AUD_ADCLRCK;
    logic               AUD_ADCDAT;
    logic signed [31:0] out_L;
    logic signed [31:0] out_R;
    logic               tick;
    logic               locked;
    logic               frame_err;
    logic               clr_err;

    int          n_vec = 0;
    int          n_bad = 0;
    int          wide  = 0;
    logic        tick_d = 1'b0;
    logic [63:0] mon_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] last_exp;
    logic        exp_err;

    i2s_sample_rx #(.DATA_BITS(DB), .TIMEOUT_CYCLES(4096)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .AUD_BCLK   (AUD_BCLK),
        .AUD_ADCLRCK(AUD_ADCLRCK),
        .AUD_ADCDAT (AUD_ADCDAT),
        .out_L      (out_L),
        .out_R      (out_R),
        .tick       (tick),
        .locked     (locked),
        .frame_err  (frame_err),
        .clr_err    (clr_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (tick)
            mon_q.push_back({out_L, out_R});
        if (tick && tick_d)
            wide++;
        tick_d = tick;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Word as seen after len edges of a slot: edge 0 is the boundary, edges 1..DB carry bits.
    function automatic logic [31:0] aligned(input logic [31:0] w, input int len);
        int          n;
        logic [63:0] v;
        n = (len - 1 > DB) ? DB : len - 1;
        v = 64'(w & ((32'd1 << DB) - 32'd1)) >> (DB - n);
        return 32'(v << (32 - n));
    endfunction

    task automatic bclk_edge(input logic lrv, input logic d);
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = lrv;
        AUD_ADCDAT  = d;
        #163;
        AUD_BCLK = 1'b1;
        #163;
    endtask

    task automatic send_slot(input logic lrv, input logic [31:0] w, input int len);
        logic d;
        for (int j = 0; j < len; j++) begin
            d = 1'($urandom);
            if (j >= 1 && j <= DB)
                d = w[DB - j];
            bclk_edge(lrv, d);
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input int ll,
                              input logic [31:0] r, input int rl);
        send_slot(1'b0, l, ll);
        send_slot(1'b1, r, rl);
        last_exp = {aligned(l, ll), aligned(r, rl)};
        exp_q.push_back(last_exp);
        if (ll <= DB || rl <= DB)
            exp_err = 1'b1;
    endtask

    task automatic check_pairs(input string tag);
        logic [63:0] e;
        logic [63:0] g;
        check({tag, "_ticks"}, 64'(mon_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 'x;
            if (mon_q.size() > 0)
                g = mon_q.pop_front();
            check({tag, "_pair"}, g, e);
        end
        mon_q.delete();
    endtask

    task automatic pulse_clr();
        @(posedge CLOCK_50);
        #1 clr_err = 1'b1;
        @(posedge CLOCK_50);
        #1 clr_err = 1'b0;
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        logic [31:0] base;
        logic [31:0] lw;
        logic [31:0] rw;
        int          ll;
        int          rl;

        reset_n     = 1'b0;
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = 1'b1;
        AUD_ADCDAT  = 1'b0;
        clr_err     = 1'b0;
        exp_err     = 1'b0;
        last_exp    = '0;
        repeat (5) @(posedge CLOCK_50);
        #1;
        check("rst_out_L", 64'(out_L), 64'(0));
        check("rst_out_R", 64'(out_R), 64'(0));
        check("rst_tick", 64'(tick), 64'(0));
        check("rst_locked", 64'(locked), 64'(0));
        check("rst_frame_err", 64'(frame_err), 64'(0));

        // Release mid right slot: partial word must not tick
        @(posedge CLOCK_50);
        #3 reset_n = 1'b1;
        send_slot(1'b1, $urandom, 12);
        check_pairs("partial_right");
        send_frame(32'h123456, FULL, 32'hABCDEF, FULL);
        check_pairs("basic");
        check("basic_locked", 64'(locked), 64'(1));
        check("basic_err", 64'(frame_err), 64'(0));

        // Ten consecutive incrementing frames
        base = $urandom;
        for (int i = 0; i < 10; i++)
            send_frame(base + 32'(i), FULL, ~(base + 32'(i)), FULL);
        check_pairs("ten");
        check("ten_err", 64'(frame_err), 64'(0));

        // Right slot cut after 20 bits of all-ones
        lw = $urandom;
        send_frame(lw, FULL, 32'hFFFFFF, 21);
        check("short_pair_R", 64'(aligned(32'hFFFFFF, 21)), 64'h0000_0000_FFFF_F000);
        send_frame($urandom, FULL, $urandom, FULL);
        check_pairs("short_right");
        check("short_err_set", 64'(frame_err), 64'(1));
        pulse_clr();
        check("short_err_clr", 64'(frame_err), 64'(0));

        // Random mix of full and short slots
        exp_err = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ll = ($urandom_range(0, 1) == 1) ? FULL : int'($urandom_range(2, DB));
            rl = ($urandom_range(0, 1) == 1) ? FULL : int'($urandom_range(2, DB));
            lw = $urandom;
            rw = $urandom;
            send_frame(lw, ll, rw, rl);
        end
        send_frame($urandom, FULL, $urandom, FULL);
        check_pairs("random");
        check("random_err", 64'(frame_err), 64'(exp_err));
        pulse_clr();
        check("random_err_clr", 64'(frame_err), 64'(0));
        check("random_locked", 64'(locked), 64'(1));

        // Stall BCLK well past the watchdog limit
        AUD_BCLK = 1'b0;
        repeat (5000) @(posedge CLOCK_50);
        #1;
`ifdef I2S_RX_TIMEOUT_EN
        check("stall_locked", 64'(locked), 64'(0));
        check("stall_out", {out_L, out_R}, 64'(0));
`else
        check("stall_locked", 64'(locked), 64'(1));
        check("stall_out", {out_L, out_R}, last_exp);
`endif
        check_pairs("stall");
        send_frame($urandom, FULL, $urandom, FULL);
        check_pairs("resume");
        check("resume_locked", 64'(locked), 64'(1));

        // Asynchronous reset mid right slot
        send_slot(1'b0, $urandom, FULL);
        send_slot(1'b1, $urandom, 10);
        @(posedge CLOCK_50);
        #7 reset_n = 1'b0;
        #1;
        check("async_out", {out_L, out_R}, 64'(0));
        check("async_tick", 64'(tick), 64'(0));
        check("async_locked", 64'(locked), 64'(0));
        repeat (3) @(posedge CLOCK_50);
        #3 reset_n = 1'b1;
        send_slot(1'b1, $urandom, 23);
        check_pairs("async_partial");
        check("async_out_hold", {out_L, out_R}, 64'(0));
        send_frame($urandom, FULL, $urandom, FULL);
        check_pairs("async_after");
        check("async_locked2", 64'(locked), 64'(1));
        check("tick_width", 64'(wide), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
